// File: rtl/screen_text_buffer.sv
// screen_text_buffer: parametrised text-mode screen memory (COLS x ROWS cells).
// CPU write port plus registered CPU and VGA read ports, a hardware clear
// engine that runs after reset and on CLEAR_REQ, and an optional one-row
// scroll-up engine built only when SCREEN_SCROLL_EN is defined.
module screen_text_buffer #(
  parameter int                 DATA_W    = 16,
  parameter int                 COLS      = 40,
  parameter int                 ROWS      = 30,
  parameter int                 ADDR_W    = 16,
  parameter logic [DATA_W-1:0]  CLEAR_VAL = '0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              MW_SCREEN_ON,
  input  logic [ADDR_W-1:0] WADDR_SCREEN,
  input  logic [DATA_W-1:0] DATA_IN_SCREEN,
  input  logic [ADDR_W-1:0] RADDR_SCREEN,
  output logic [DATA_W-1:0] DATA_OUT_SCREEN,
  input  logic [ADDR_W-1:0] VGA_RADDR,
  output logic [DATA_W-1:0] VGA_DATA,
  input  logic              CLEAR_REQ,
  input  logic              SCROLL_REQ,
  output logic              BUSY,
  output logic              DONE,
  output logic              WR_DROP
);

  localparam int DEPTH = COLS * ROWS;
  localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [CNT_W-1:0]  LAST_C  = CNT_W'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_COPY, S_FILL} state_t;

  logic [DATA_W-1:0] mem_q [DEPTH];
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, done_q, drop_q;
  logic [DATA_W-1:0] cpu_rd_q, vga_rd_q;
  logic              we;
  logic [CNT_W-1:0]  waddr;
  logic [DATA_W-1:0] wdata;

`ifdef SCREEN_SCROLL_EN
  localparam logic [CNT_W-1:0] SCR_END_C = CNT_W'(DEPTH - COLS);
  localparam logic [CNT_W-1:0] COLS_C    = CNT_W'(COLS);
  logic [DATA_W-1:0] copy_q;

  // Copy pipeline: fetch the word one row below; it is written back one cycle later.
  always_ff @(posedge CLK) begin
    if (state_q == S_COPY && cnt_q != SCR_END_C) begin
      copy_q <= mem_q[cnt_q + COLS_C];
    end
  end
`else
  logic unused_scroll;
  assign unused_scroll = SCROLL_REQ;
`endif

  // Next-state and single memory write-port arbitration (engines own the port while busy).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we      = 1'b0;
    waddr   = '0;
    wdata   = CLEAR_VAL;
    case (state_q)
      S_IDLE: begin
        if (MW_SCREEN_ON && (WADDR_SCREEN < DEPTH_A)) begin
          we    = 1'b1;
          waddr = WADDR_SCREEN[CNT_W-1:0];
          wdata = DATA_IN_SCREEN;
        end
        if (CLEAR_REQ) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
`ifdef SCREEN_SCROLL_EN
        else if (SCROLL_REQ) begin
          state_d = S_COPY;
          cnt_d   = '0;
        end
`endif
      end
      S_CLEAR: begin
        we    = 1'b1;
        waddr = cnt_q;
        if (cnt_q == LAST_C) state_d = S_IDLE;
        else                 cnt_d   = cnt_q + CNT_W'(1);
      end
`ifdef SCREEN_SCROLL_EN
      // cnt is the source-row offset; the write trails it by one (cnt 0 only primes).
      S_COPY: begin
        we    = (cnt_q != '0);
        waddr = cnt_q - CNT_W'(1);
        wdata = copy_q;
        if (cnt_q == SCR_END_C) state_d = S_FILL;  // cnt already points at the last row
        else                    cnt_d   = cnt_q + CNT_W'(1);
      end
      S_FILL: begin
        we    = 1'b1;
        waddr = cnt_q;
        if (cnt_q == LAST_C) state_d = S_IDLE;
        else                 cnt_d   = cnt_q + CNT_W'(1);
      end
`endif
      default: state_d = S_IDLE;
    endcase
    if (!RST_N) we = 1'b0;
  end

  // Control registers: reset forces a fresh full clear from address 0.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_q != S_IDLE) && (state_d == S_IDLE);
      if (busy_q && MW_SCREEN_ON) drop_q <= 1'b1;
    end
  end

  // Memory write port; reads on the same edge see the old contents.
  always_ff @(posedge CLK) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Registered CPU and VGA read ports; out-of-range addresses read as zero.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cpu_rd_q <= '0;
      vga_rd_q <= '0;
    end else begin
      cpu_rd_q <= (RADDR_SCREEN < DEPTH_A) ? mem_q[RADDR_SCREEN[CNT_W-1:0]] : '0;
      vga_rd_q <= (VGA_RADDR < DEPTH_A) ? mem_q[VGA_RADDR[CNT_W-1:0]] : '0;
    end
  end

  assign DATA_OUT_SCREEN = cpu_rd_q;
  assign VGA_DATA        = vga_rd_q;
  assign BUSY            = busy_q;
  assign DONE            = done_q;
  assign WR_DROP         = drop_q;

endmodule

// File: tb/tb_screen_text_buffer.sv
// Directed bench for screen_text_buffer (default 40x30 geometry).
// The scroll section runs only when SCREEN_SCROLL_EN is defined; otherwise
// SCROLL_REQ is checked to be ignored.
module tb_screen_text_buffer;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        MW_SCREEN_ON;
  logic [15:0] WADDR_SCREEN;
  logic [15:0] DATA_IN_SCREEN;
  logic [15:0] RADDR_SCREEN;
  logic [15:0] DATA_OUT_SCREEN;
  logic [15:0] VGA_RADDR;
  logic [15:0] VGA_DATA;
  logic        CLEAR_REQ;
  logic        SCROLL_REQ;
  logic        BUSY;
  logic        DONE;
  logic        WR_DROP;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  screen_text_buffer dut (
    .CLK(CLK), .RST_N(RST_N),
    .MW_SCREEN_ON(MW_SCREEN_ON), .WADDR_SCREEN(WADDR_SCREEN), .DATA_IN_SCREEN(DATA_IN_SCREEN),
    .RADDR_SCREEN(RADDR_SCREEN), .DATA_OUT_SCREEN(DATA_OUT_SCREEN),
    .VGA_RADDR(VGA_RADDR), .VGA_DATA(VGA_DATA),
    .CLEAR_REQ(CLEAR_REQ), .SCROLL_REQ(SCROLL_REQ),
    .BUSY(BUSY), .DONE(DONE), .WR_DROP(WR_DROP)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input int a, output logic [15:0] d, output logic [15:0] v);
    @(negedge CLK);
    RADDR_SCREEN = 16'(a);
    VGA_RADDR    = 16'(a);
    @(posedge CLK);
    #1;
    d = DATA_OUT_SCREEN;
    v = VGA_DATA;
  endtask

  task automatic wr(input int a, input logic [15:0] d);
    @(negedge CLK);
    MW_SCREEN_ON   = 1'b1;
    WADDR_SCREEN   = 16'(a);
    DATA_IN_SCREEN = d;
    @(negedge CLK);
    MW_SCREEN_ON   = 1'b0;
  endtask

  task automatic pulse(input logic clr, input logic scr);
    @(negedge CLK);
    CLEAR_REQ  = clr;
    SCROLL_REQ = scr;
    @(negedge CLK);
    CLEAR_REQ  = 1'b0;
    SCROLL_REQ = 1'b0;
  endtask

  // Counts negedges with BUSY high from the current one, then DONE pulses.
  task automatic measure(input int start, output int n, output int dn);
    n  = start;
    dn = 0;
    while (BUSY === 1'b1 && n < 5000) begin
      n++;
      if (DONE === 1'b1) dn++;
      @(negedge CLK);
    end
    for (int k = 0; k < 3; k++) begin
      if (DONE === 1'b1) dn++;
      @(negedge CLK);
    end
  endtask

  task automatic sweep_zero(input int lo, input int hi, output int nz);
    logic [15:0] d, v;
    nz = 0;
    for (int i = lo; i <= hi; i++) begin
      rd(i, d, v);
      if (d !== 16'h0 || v !== 16'h0) nz++;
    end
  endtask

  initial begin
    logic [15:0] d, v;
    int n, dn, nz;
    RST_N = 1'b0; MW_SCREEN_ON = 1'b0; WADDR_SCREEN = '0; DATA_IN_SCREEN = '0;
    RADDR_SCREEN = '0; VGA_RADDR = '0; CLEAR_REQ = 1'b0; SCROLL_REQ = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_busy", BUSY, 1);
    chk("rst_done", DONE, 0);
    chk("rst_wrdrop", WR_DROP, 0);
    chk("rst_dout", DATA_OUT_SCREEN, 0);
    chk("rst_vga", VGA_DATA, 0);

    // Power-up clear
    RST_N = 1'b1;
    measure(0, n, dn);
    chk("init_busy_cycles", n, 1200);
    chk("init_done_pulses", dn, 1);
    sweep_zero(0, 1199, nz);
    chk("init_all_zero", nz, 0);

    // Basic write/read and out-of-range handling
    wr(600, 16'h0057);
    rd(600, d, v);
    chk("rd600_cpu", d, 16'h0057);
    chk("rd600_vga", v, 16'h0057);
    rd(1200, d, v);
    chk("rd1200_cpu", d, 0);
    chk("rd1200_vga", v, 0);
    wr(1200, 16'hBEEF);
    chk("oor_wr_nodrop", WR_DROP, 0);
    rd(1200, d, v);
    chk("rd1200_after_wr", d, 0);
    rd(176, d, v);
    chk("rd176_untouched", d, 0);
    rd(600, d, v);
    chk("rd600_kept", d, 16'h0057);

    // Same-edge write and read: old value first, then new
    @(negedge CLK);
    MW_SCREEN_ON = 1'b1; WADDR_SCREEN = 16'd10; DATA_IN_SCREEN = 16'h1234;
    VGA_RADDR = 16'd10; RADDR_SCREEN = 16'd10;
    @(posedge CLK); #1;
    chk("rbw_vga_old", VGA_DATA, 0);
    chk("rbw_cpu_old", DATA_OUT_SCREEN, 0);
    @(negedge CLK);
    MW_SCREEN_ON = 1'b0;
    @(posedge CLK); #1;
    chk("rbw_vga_new", VGA_DATA, 16'h1234);

    // Clear and scroll requested together: clear wins; write during busy is dropped
    pulse(1'b1, 1'b1);
    MW_SCREEN_ON = 1'b1; WADDR_SCREEN = 16'd5; DATA_IN_SCREEN = 16'hFFFF;
    @(negedge CLK);
    MW_SCREEN_ON = 1'b0;
    measure(1, n, dn);
    chk("clr_busy_cycles", n, 1200);
    chk("clr_done_pulses", dn, 1);
    chk("clr_wrdrop", WR_DROP, 1);
    sweep_zero(0, 1199, nz);
    chk("clr_all_zero", nz, 0);

    // Reset in the middle of a clear restarts a full clear
    wr(20, 16'h00AA);
    pulse(1'b1, 1'b0);
    repeat (50) @(negedge CLK);
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    chk("midclr_rst_wrdrop", WR_DROP, 0);
    chk("midclr_rst_busy", BUSY, 1);
    RST_N = 1'b1;
    measure(0, n, dn);
    chk("midclr_busy_cycles", n, 1200);
    chk("midclr_done_pulses", dn, 1);

`ifdef SCREEN_SCROLL_EN
    // Scroll one row up
    for (int i = 0; i < 1200; i++) begin
      @(negedge CLK);
      MW_SCREEN_ON = 1'b1; WADDR_SCREEN = 16'(i); DATA_IN_SCREEN = 16'(i + 1);
    end
    @(negedge CLK);
    MW_SCREEN_ON = 1'b0;
    rd(1199, d, v);
    chk("fill_1199", d, 16'd1200);
    pulse(1'b0, 1'b1);
    MW_SCREEN_ON = 1'b1; WADDR_SCREEN = 16'd5; DATA_IN_SCREEN = 16'hFFFF;
    @(negedge CLK);
    MW_SCREEN_ON = 1'b0;
    measure(1, n, dn);
    chk("scr_busy_cycles", n, 1201);
    chk("scr_done_pulses", dn, 1);
    chk("scr_wrdrop", WR_DROP, 1);
    rd(0, d, v);
    chk("scr_addr0", d, 16'd41);
    rd(5, d, v);
    chk("scr_addr5", d, 16'd46);
    rd(1159, d, v);
    chk("scr_addr1159", d, 16'd1200);
    nz = 0;
    for (int a = 0; a < 1160; a++) begin
      rd(a, d, v);
      if (d !== 16'(a + 41) || v !== 16'(a + 41)) nz++;
    end
    chk("scr_copy_all", nz, 0);
    sweep_zero(1160, 1199, nz);
    chk("scr_fill_zero", nz, 0);

    // Reset in the middle of a scroll
    pulse(1'b0, 1'b1);
    repeat (100) @(negedge CLK);
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    chk("midscr_rst_busy", BUSY, 1);
    chk("midscr_rst_wrdrop", WR_DROP, 0);
    RST_N = 1'b1;
    measure(0, n, dn);
    chk("midscr_busy_cycles", n, 1200);
    chk("midscr_done_pulses", dn, 1);
    sweep_zero(0, 1199, nz);
    chk("midscr_all_zero", nz, 0);
`else
    // Scroll engine absent: request is ignored
    pulse(1'b0, 1'b1);
    measure(0, n, dn);
    chk("noscr_busy_cycles", n, 0);
    chk("noscr_done_pulses", dn, 0);
    wr(7, 16'h0077);
    rd(7, d, v);
    chk("noscr_wr_after", d, 16'h0077);
    chk("noscr_wrdrop", WR_DROP, 0);
    sweep_zero(0, 6, nz);
    chk("midclr_low_zero", nz, 0);
    sweep_zero(8, 1199, nz);
    chk("midclr_high_zero", nz, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
